adder_share_arbiter: RTL and testbench

- Shares the single adder_16_bit instance between up to 4 requesters, e.g. PC increment, ALU add and branch-target calculation, using round-robin arbitration.
- Captures the winner's operands, runs them through the adder and returns a registered result tagged with the winner's ID.
- Sits between the control unit's add requests and the adder_16_bit datapath instance.

---
 rtl/adder_share_arbiter.sv | 166 ++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin share of one 16-bit adder between NREQ requesters
// Optional overflow flag output enabled by defining ADDER_ARB_OVF_EN.

// Fixed-width datapath adder; carry-out is intentionally not produced.
module adder_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s
);
  assign s = a + b;
endmodule

module adder_share_arbiter #(
  parameter int NREQ = 3,
  parameter int W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   grant,
  output logic [W-1:0]      R,
  output logic              done,
`ifdef ADDER_ARB_OVF_EN
  output logic              ovf,
`endif
  output logic [1:0]        done_id
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      win_q, win_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [W-1:0]    r_q, r_d;
  logic            done_q, done_d;
  logic [1:0]      done_id_q, done_id_d;
`ifdef ADDER_ARB_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  // Requests and operands widened to four lanes so a 2-bit index always selects cleanly
  logic [3:0]   req_ext;
  logic [W-1:0] a_arr [4];
  logic [W-1:0] b_arr [4];
  logic [W-1:0] sum;

  assign req_ext = 4'(req);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    if (i < NREQ) begin : g_used
      assign a_arr[i] = a_in[i*W +: W];
      assign b_arr[i] = b_in[i*W +: W];
    end else begin : g_unused
      assign a_arr[i] = '0;
      assign b_arr[i] = '0;
    end
  end

  adder_16_bit u_adder (
    .a (a_q),
    .b (b_q),
    .s (sum)
  );

  // Round-robin search: the lowest offset from rr_ptr with a set request wins
  logic       found;
  logic [1:0] win_idx;
  always_comb begin
    logic [2:0] pos;
    found   = 1'b0;
    win_idx = 2'd0;
    pos     = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr_q} + 3'(k);
      if (pos >= 3'(NREQ)) pos = pos - 3'(NREQ);
      if (req_ext[pos[1:0]]) begin
        found   = 1'b1;
        win_idx = pos[1:0];
      end
    end
  end

  // Next-state logic: capture winner in IDLE, produce the registered sum in EXEC
  always_comb begin
    logic [3:0] grant_ext;
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    a_d       = a_q;
    b_d       = b_q;
    grant_ext = 4'd0;
    r_d       = r_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
`ifdef ADDER_ARB_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_ext[win_idx] = 1'b1;
          a_d     = a_arr[win_idx];
          b_d     = b_arr[win_idx];
          win_d   = win_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        r_d       = sum;
        done_d    = 1'b1;
        done_id_d = win_q;
        rr_ptr_d  = (win_q == 2'(NREQ - 1)) ? 2'd0 : win_q + 2'd1;
`ifdef ADDER_ARB_OVF_EN
        ovf_d     = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
`endif
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    grant_d = grant_ext[NREQ-1:0];
  end

  // State and registered outputs; reset wins over everything, including an in-flight add
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 2'd0;
      win_q     <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      grant_q   <= '0;
      r_q       <= '0;
      done_q    <= 1'b0;
      done_id_q <= 2'd0;
`ifdef ADDER_ARB_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      a_q       <= a_d;
      b_q       <= b_d;
      grant_q   <= grant_d;
      r_q       <= r_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
`ifdef ADDER_ARB_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign R       = r_q;
  assign done    = done_q;
  assign done_id = done_id_q;
`ifdef ADDER_ARB_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - directed self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   grant;
  logic [W-1:0]      R;
  logic              done;
  logic [1:0]        done_id;
`ifdef ADDER_ARB_OVF_EN
  logic              ovf;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 CLK = ~CLK;

  adder_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .grant   (grant),
    .R       (R),
    .done    (done),
`ifdef ADDER_ARB_OVF_EN
    .ovf     (ovf),
`endif
    .done_id (done_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One request on lane idx; waits (bounded) for the grant, drops req, checks the result
  task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input bit full, input string tag);
    int n;
    a_in[idx*W +: W] = a;
    b_in[idx*W +: W] = b;
    req[idx] = 1'b1;
    n = 0;
    @(negedge CLK);
    while (grant == '0 && n < 8) begin
      @(negedge CLK);
      n++;
    end
    if (grant == '0) begin
      check({tag, "_grant_timeout"}, 32'd0, 32'd1);
      req[idx] = 1'b0;
      return;
    end
    if (full) begin
      check({tag, "_grant"}, 32'(grant), 32'(1 << idx));
      check({tag, "_done_low_at_grant"}, 32'(done), 32'd0);
    end
    req[idx] = 1'b0;
    @(negedge CLK);
    check({tag, "_R"}, 32'(R), 32'(exp));
    if (full) begin
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_done_id"}, 32'(done_id), 32'(idx));
      check({tag, "_grant_low_at_done"}, 32'(grant), 32'd0);
    end
  endtask

  initial begin
    logic [NREQ-1:0] gs [4];
    logic [1:0]      ids [3];
    logic [15:0]     rs [3];
    int ng, nd, overlap;

    RST  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(negedge CLK);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_no_grant", 32'(grant), 32'd0);

    // Single request, then R holds and done drops
    run_op(0, 16'd5, 16'd7, 16'd12, 1'b1, "single");
    @(negedge CLK);
    check("done_one_cycle", 32'(done), 32'd0);
    check("R_holds", 32'(R), 32'd12);

    // Contention from a fresh reset: order 0,1,2
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_in[i*W +: W] = 16'(100 * (i + 1));
      b_in[i*W +: W] = 16'(i + 1);
    end
    req = 3'b111;
    ng = 0; nd = 0; overlap = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (grant != '0 && done) overlap++;
      if (grant != '0 && ng < 3) begin
        gs[ng] = grant;
        ng++;
        req = req & ~grant;
      end
      if (done && nd < 3) begin
        ids[nd] = done_id;
        rs[nd]  = R;
        nd++;
      end
    end
    check("cont_ngrants", 32'(ng), 32'd3);
    check("cont_ndone", 32'(nd), 32'd3);
    check("cont_g0", 32'(gs[0]), 32'b001);
    check("cont_g1", 32'(gs[1]), 32'b010);
    check("cont_g2", 32'(gs[2]), 32'b100);
    check("cont_id0", 32'(ids[0]), 32'd0);
    check("cont_id1", 32'(ids[1]), 32'd1);
    check("cont_id2", 32'(ids[2]), 32'd2);
    check("cont_r0", 32'(rs[0]), 32'd101);
    check("cont_r1", 32'(rs[1]), 32'd202);
    check("cont_r2", 32'(rs[2]), 32'd303);
    check("cont_no_overlap", 32'(overlap), 32'd0);

    // Starvation: req0 and req2 held; rr_ptr back at 0 so order is 0,2,0,2
    req = 3'b101;
    ng = 0; overlap = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (grant != '0 && done) overlap++;
      if (grant != '0 && ng < 4) begin
        gs[ng] = grant;
        ng++;
      end
    end
    req = '0;
    repeat (2) @(negedge CLK);
    check("starve_ngrants", 32'(ng), 32'd4);
    check("starve_g0", 32'(gs[0]), 32'b001);
    check("starve_g1", 32'(gs[1]), 32'b100);
    check("starve_g2", 32'(gs[2]), 32'b001);
    check("starve_g3", 32'(gs[3]), 32'b100);
    check("starve_no_overlap", 32'(overlap), 32'd0);

    // Wrap-around arithmetic
    run_op(1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, "wrap");
    run_op(2, 16'hFFEC, 16'hFFEC, 16'hFFD8, 1'b1, "neg20");
`ifdef ADDER_ARB_OVF_EN
    check("ovf_clear", 32'(ovf), 32'd0);
    run_op(0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, "ovf_pos");
    check("ovf_set", 32'(ovf), 32'd1);
    @(negedge CLK);
    check("ovf_holds", 32'(ovf), 32'd1);
`endif

    // Operand stability: a_in changes right after the grant
    a_in[0 +: W] = 16'd10;
    b_in[0 +: W] = 16'd5;
    req[0] = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge CLK);
      while (grant == '0 && n < 8) begin
        @(negedge CLK);
        n++;
      end
      check("stab_grant", 32'(grant), 32'b001);
      a_in[0 +: W] = 16'd99;
      req[0] = 1'b0;
      @(negedge CLK);
      check("stab_R", 32'(R), 32'd15);
    end

    // Signed sweep -20..19 x -20..19 on lane 1
    for (int a = -20; a < 20; a++) begin
      for (int b = -20; b < 20; b++) begin
        run_op(1, 16'(a), 16'(b), 16'(a + b), 1'b0, "sweep");
      end
    end

    // Reset during EXEC drops the add; rr_ptr returns to 0
    a_in[2*W +: W] = 16'd1;
    b_in[2*W +: W] = 16'd2;
    req = 3'b100;
    begin
      int n;
      n = 0;
      @(negedge CLK);
      while (grant == '0 && n < 8) begin
        @(negedge CLK);
        n++;
      end
      check("rstmid_grant", 32'(grant), 32'b100);
    end
    req = '0;
    RST = 1'b1;
    @(negedge CLK);
    check("rstmid_no_done", 32'(done), 32'd0);
    check("rstmid_grant0", 32'(grant), 32'd0);
    check("rstmid_R0", 32'(R), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("rstmid_still_no_done", 32'(done), 32'd0);
    a_in[1*W +: W] = 16'd30;
    b_in[1*W +: W] = 16'd12;
    a_in[2*W +: W] = 16'd7;
    b_in[2*W +: W] = 16'd8;
    req = 3'b110;
    @(negedge CLK);
    check("rstmid_rr_restart", 32'(grant), 32'b010);
    req[1] = 1'b0;
    @(negedge CLK);
    check("rstmid_done", 32'(done), 32'd1);
    check("rstmid_id", 32'(done_id), 32'd1);
    check("rstmid_R", 32'(R), 32'd42);
    @(negedge CLK);
    check("rstmid_next_grant", 32'(grant), 32'b100);
    req = '0;
    @(negedge CLK);
    check("rstmid_next_R", 32'(R), 32'd15);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
